// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU execute stage and a DMA requester.
// Define DMEM_ARB_STATS_EN to add saturating stall / DMA-grant statistics outputs.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [7:0]  dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_stall,
  output logic [15:0] stat_dma
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  localparam logic [CNT_W-1:0] WAIT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);

  logic [0:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             dma_ok;
  logic             starved;
  logic             grant_dma;
  logic             grant_cpu;

  // A limit of zero means the DMA always wins, so no counter comparison is needed.
  generate
    if (STARVE_LIMIT == 0) begin : g_strict
      assign starved = 1'b1;
    end else begin : g_limit
      assign starved = (wait_cnt >= LIMIT);
    end
  endgenerate

  assign dma_ok    = dma_req & (state == IDLE) & ~reset;
  assign grant_dma = dma_ok & (~cpu_req | starved);
  assign grant_cpu = cpu_req & ~grant_dma & ~reset;

  assign cpu_stall = cpu_req & grant_dma;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (grant_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end else if (grant_cpu) begin
      mem_we    = cpu_we;
    end
  end

  // The ACK state blocks a second DMA grant, limiting DMA to one access every two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      dma_ack   <= 1'b0;
      dma_rdata <= 8'h00;
    end else begin
      dma_ack <= grant_dma;
      state   <= grant_dma ? ACK : IDLE;
      if (grant_dma) begin
        dma_rdata <= mem_rdata;
      end
      if (grant_dma || !dma_req) begin
        wait_cnt <= '0;
      end else if (dma_ok && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall <= 16'h0000;
      stat_dma   <= 16'h0000;
    end else begin
      if (cpu_stall && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'h0001;
      end
      if (grant_dma && (stat_dma != 16'hFFFF)) begin
        stat_dma <= stat_dma + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table, a STARVE_LIMIT=0 instance,
// and randomized traffic checked against a cycle-level reference model of the arbitration rules.
module tb_dmem_port_arbiter;

  localparam int LIMIT    = 4;
  localparam int WAIT_SAT = 15;

  typedef struct {
    bit         rst;
    bit         cr;
    bit         cw;
    logic [7:0] ca;
    logic [7:0] cd;
    bit         dr;
    bit         dw;
    logic [7:0] da;
    logic [7:0] dd;
    bit         e_we;
    bit         e_stall;
    bit         e_ack;
    logic [7:0] e_rdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_stall, dma_ack, mem_we;

  logic       z_reset, z_cpu_req, z_cpu_we, z_dma_req, z_dma_we;
  logic [7:0] z_cpu_addr, z_cpu_wdata, z_dma_addr, z_dma_wdata;
  logic [7:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_wdata;
  logic [7:0] z_mem_rdata = 8'h5A;
  logic       z_cpu_stall, z_dma_ack, z_mem_we;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall, stat_dma, z_stat_stall, z_stat_dma;
`endif

  dmem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_stall(stat_stall), .stat_dma(stat_dma)
`endif
  );

  dmem_port_arbiter #(.STARVE_LIMIT(0), .CNT_W(4)) dut_strict (
    .clk(clk), .reset(z_reset),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
    .dma_req(z_dma_req), .dma_we(z_dma_we), .dma_addr(z_dma_addr), .dma_wdata(z_dma_wdata),
    .dma_ack(z_dma_ack), .dma_rdata(z_dma_rdata),
    .mem_addr(z_mem_addr), .mem_we(z_mem_we), .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_stall(z_stat_stall), .stat_dma(z_stat_dma)
`endif
  );

  // Data memory attached to the main instance: combinational read, synchronous write.
  logic [7:0] mem [256];
  logic       mem_load;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h1C;
    end else if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: memory image, consecutive refused DMA cycles, and the pending acknowledge.
  logic [7:0] ref_mem [256];
  int         m_wait;
  bit         m_ack;
  logic [7:0] m_rdata;
  bit         x_gdma, x_gcpu, x_we;
  logic [7:0] x_addr, x_wdata;

  task automatic model_eval();
    x_gdma  = !reset && dma_req && !m_ack && (!cpu_req || m_wait >= LIMIT);
    x_gcpu  = !reset && cpu_req && !x_gdma;
    x_we    = (x_gdma && dma_we) || (x_gcpu && cpu_we);
    x_addr  = x_gdma ? dma_addr : cpu_addr;
    x_wdata = x_gdma ? dma_wdata : cpu_wdata;
  endtask

  task automatic model_commit();
    if (reset) begin
      m_ack = 0; m_rdata = 8'h00; m_wait = 0;
    end else begin
      if (x_gdma) m_rdata = ref_mem[dma_addr];
      if (x_we) ref_mem[x_addr] = x_wdata;
      if (x_gdma || !dma_req) m_wait = 0;
      else if (!m_ack) m_wait = (m_wait < WAIT_SAT) ? m_wait + 1 : WAIT_SAT;
      m_ack = x_gdma;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_cycle(input bit use_table, input int tag, input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    model_eval();
    if (use_table) begin
      checkOutput($sformatf("row%0d_mem_we", tag), 16'(mem_we), 16'(v.e_we));
      checkOutput($sformatf("row%0d_cpu_stall", tag), 16'(cpu_stall), 16'(v.e_stall));
      checkOutput($sformatf("row%0d_dma_ack", tag), 16'(dma_ack), 16'(v.e_ack));
      checkOutput($sformatf("row%0d_dma_rdata", tag), 16'(dma_rdata), 16'(v.e_rdata));
    end else begin
      checkOutput($sformatf("rnd%0d_mem_we", tag), 16'(mem_we), 16'(x_we));
      checkOutput($sformatf("rnd%0d_cpu_stall", tag), 16'(cpu_stall), 16'(cpu_req && x_gdma));
      checkOutput($sformatf("rnd%0d_dma_ack", tag), 16'(dma_ack), 16'(m_ack));
      checkOutput($sformatf("rnd%0d_dma_rdata", tag), 16'(dma_rdata), 16'(m_rdata));
      checkOutput($sformatf("rnd%0d_cpu_rdata", tag), 16'(cpu_rdata), 16'(ref_mem[x_addr]));
      if (x_we) begin
        checkOutput($sformatf("rnd%0d_mem_addr", tag), 16'(mem_addr), 16'(x_addr));
        checkOutput($sformatf("rnd%0d_mem_wdata", tag), 16'(mem_wdata), 16'(x_wdata));
      end
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  function automatic vec_t row(input bit rst, input bit cr, input bit cw, input logic [7:0] ca,
                               input logic [7:0] cd, input bit dr, input bit dw,
                               input logic [7:0] da, input logic [7:0] dd, input bit we,
                               input bit st, input bit ack, input logic [7:0] rd);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_we = we; v.e_stall = st; v.e_ack = ack; v.e_rdata = rd;
    return v;
  endfunction

  vec_t vecs [30];
  vec_t rv;
  bit   pend;
  int   bad;

  initial begin
    // Memory starts as addr ^ 8'h1C, so 0x20 holds 0x3C, 0x21 -> 0x3D, 0x30 -> 0x2C, 0x80 -> 0x9C.
    vecs[0]  = row(1, 1, 1, 8'h01, 8'hFF, 1, 1, 8'h02, 8'hFF, 0, 0, 0, 8'h00);
    vecs[1]  = row(0, 1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00);
    vecs[2]  = row(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00);
    vecs[3]  = row(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h3C);
    vecs[4]  = row(0, 1, 1, 8'h40, 8'h01, 1, 1, 8'h80, 8'hEE, 1, 0, 0, 8'h3C);
    vecs[5]  = row(0, 1, 1, 8'h41, 8'h02, 1, 1, 8'h80, 8'hEE, 1, 0, 0, 8'h3C);
    vecs[6]  = row(0, 1, 1, 8'h42, 8'h03, 1, 1, 8'h80, 8'hEE, 1, 0, 0, 8'h3C);
    vecs[7]  = row(0, 1, 1, 8'h43, 8'h04, 1, 1, 8'h80, 8'hEE, 1, 0, 0, 8'h3C);
    vecs[8]  = row(0, 1, 1, 8'h44, 8'h05, 1, 1, 8'h80, 8'hEE, 1, 1, 0, 8'h3C);
    vecs[9]  = row(0, 1, 1, 8'h44, 8'h05, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h9C);
    vecs[10] = row(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h77, 1, 0, 0, 8'h9C);
    vecs[11] = row(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h77, 0, 0, 1, 8'h3D);
    vecs[12] = row(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h77, 1, 0, 0, 8'h3D);
    vecs[13] = row(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h77, 0, 0, 1, 8'h77);
    vecs[14] = row(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h77, 1, 0, 0, 8'h77);
    vecs[15] = row(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h77, 0, 0, 1, 8'h77);
    vecs[16] = row(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h77);
    vecs[17] = row(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h11, 1, 0, 0, 8'h77);
    vecs[18] = row(1, 1, 1, 8'h60, 8'h22, 1, 1, 8'h30, 8'h11, 0, 0, 1, 8'h2C);
    vecs[19] = row(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    vecs[20] = row(0, 1, 0, 8'h50, 8'h00, 1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00);
    vecs[21] = row(0, 1, 0, 8'h50, 8'h00, 1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00);
    vecs[22] = row(1, 1, 0, 8'h50, 8'h00, 1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00);
    vecs[23] = row(0, 1, 0, 8'h50, 8'h00, 1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00);
    vecs[24] = row(0, 1, 0, 8'h50, 8'h00, 1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00);
    vecs[25] = row(0, 1, 0, 8'h50, 8'h00, 1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00);
    vecs[26] = row(0, 1, 0, 8'h50, 8'h00, 1, 0, 8'h31, 8'h00, 0, 0, 0, 8'h00);
    vecs[27] = row(0, 1, 0, 8'h50, 8'h00, 1, 0, 8'h31, 8'h00, 0, 1, 0, 8'h00);
    vecs[28] = row(0, 1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h2D);
    vecs[29] = row(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h2D);

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h1C;
    m_wait = 0; m_ack = 0; m_rdata = 8'h00;
    applyStimulus(row(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00));
    mem_load = 1'b1;
    z_reset = 1'b1; z_cpu_req = 0; z_cpu_we = 0; z_cpu_addr = 8'h00; z_cpu_wdata = 8'h00;
    z_dma_req = 0; z_dma_we = 0; z_dma_addr = 8'h00; z_dma_wdata = 8'h00;
    @(posedge clk); #1;
    mem_load = 1'b0;

    // Strict-priority instance: DMA wins immediately against a CPU request.
    z_reset = 1'b0;
    z_cpu_req = 1; z_cpu_we = 1; z_cpu_addr = 8'h05; z_cpu_wdata = 8'h44;
    z_dma_req = 1; z_dma_we = 1; z_dma_addr = 8'h09; z_dma_wdata = 8'h33;
    @(negedge clk);
    checkOutput("strict_stall", 16'(z_cpu_stall), 16'd1);
    checkOutput("strict_mem_we", 16'(z_mem_we), 16'd1);
    checkOutput("strict_mem_addr", 16'(z_mem_addr), 16'h09);
    checkOutput("strict_mem_wdata", 16'(z_mem_wdata), 16'h33);
    checkOutput("strict_ack_early", 16'(z_dma_ack), 16'd0);
    @(posedge clk); #1;
    z_dma_req = 0;
    @(negedge clk);
    checkOutput("strict_ack", 16'(z_dma_ack), 16'd1);
    checkOutput("strict_rdata", 16'(z_dma_rdata), 16'h5A);
    checkOutput("strict_cpu_back", 16'(z_cpu_stall), 16'd0);
    checkOutput("strict_cpu_addr", 16'(z_mem_addr), 16'h05);
    @(posedge clk); #1;
    z_cpu_req = 0;
    @(negedge clk);
    checkOutput("strict_ack_drop", 16'(z_dma_ack), 16'd0);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("strict_stat_stall", z_stat_stall, 16'd1);
    checkOutput("strict_stat_dma", z_stat_dma, 16'd1);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) run_cycle(1'b1, i, vecs[i]);

    // Randomized traffic; the DMA requester holds its fields until acknowledged.
    pend = 0;
    rv = row(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    for (int n = 0; n < 1500; n++) begin
      if (m_ack) pend = 0;
      if (!pend && ($urandom_range(0, 2) == 0)) begin
        pend  = 1;
        rv.dw = 1'($urandom_range(0, 1));
        rv.da = 8'($urandom_range(0, 31));
        rv.dd = 8'($urandom);
      end
      rv.dr  = pend;
      rv.rst = ($urandom_range(0, 59) == 0);
      rv.cr  = ($urandom_range(0, 3) != 0);
      rv.cw  = 1'($urandom_range(0, 1));
      rv.ca  = 8'($urandom_range(0, 31));
      rv.cd  = 8'($urandom);
      run_cycle(1'b0, n, rv);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checkOutput("mem_image", 16'(bad), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
